// File: rtl/telem_frame_tx.sv
// Telemetry frame transmitter: on a snd pulse, snapshots the payload and emits
// HDR, payload bytes (MSB-byte first), then an inverted-sum checksum, pacing
// each byte on rising edges of the UART transmitter's tx_done.
`timescale 1ns / 1ps

module telem_frame_tx #(
    parameter int unsigned NUM_BYTES = 6,
    parameter logic [7:0]  HDR       = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   snd,
    input  logic [8*NUM_BYTES-1:0] payload,
    input  logic                   tx_done,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic                   frm_done
);

    localparam int unsigned IW = $clog2(NUM_BYTES + 2);
    // Index value while the checksum byte is in flight.
    localparam logic [IW-1:0] LastIdx = IW'(NUM_BYTES + 1);
    localparam logic [IW-1:0] NumB    = IW'(NUM_BYTES);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StSend = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [7:0]             acc_q, acc_d;
    logic [8*NUM_BYTES-1:0] shadow_q, shadow_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   trmt_q, trmt_d;
    logic                   busy_q, busy_d;
    logic                   frm_done_q, frm_done_d;
    logic                   tx_done_q;
    logic                   rise;
    logic [7:0]             pay_byte;

    assign rise     = tx_done & ~tx_done_q;
    assign trmt     = trmt_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign frm_done = frm_done_q;

    // Select payload byte idx_q from the shadow copy (byte 0 is the top byte).
    always_comb begin
        pay_byte = 8'h00;
        for (int i = 0; i < int'(NUM_BYTES); i++) begin
            if (idx_q == i[IW-1:0]) begin
                pay_byte = shadow_q[8*(int'(NUM_BYTES)-1-i) +: 8];
            end
        end
    end

    // Next-state and registered-output logic for the framing FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        shadow_d   = shadow_q;
        tx_data_d  = tx_data_q;
        trmt_d     = 1'b0;
        busy_d     = busy_q;
        frm_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (snd) begin
                    shadow_d  = payload;
                    tx_data_d = HDR;
                    acc_d     = HDR;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    trmt_d    = 1'b1;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (rise) begin
                    if (idx_q == LastIdx) begin
                        // Checksum byte has completed.
                        state_d    = StIdle;
                        frm_done_d = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            StSend: begin
                trmt_d  = 1'b1;
                idx_d   = idx_q + IW'(1);
                state_d = StWait;
                if (idx_q < NumB) begin
                    tx_data_d = pay_byte;
                    acc_d     = acc_q + pay_byte;
                end else begin
                    tx_data_d = ~acc_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            acc_q      <= 8'h00;
            shadow_q   <= '0;
            tx_data_q  <= 8'h00;
            trmt_q     <= 1'b0;
            busy_q     <= 1'b0;
            frm_done_q <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            shadow_q   <= shadow_d;
            tx_data_q  <= tx_data_d;
            trmt_q     <= trmt_d;
            busy_q     <= busy_d;
            frm_done_q <= frm_done_d;
            tx_done_q  <= tx_done;
        end
    end

endmodule

// File: tb/tb_telem_frame_tx.sv
// Bench for telem_frame_tx: a fast behavioural UART transmitter stands in for the
// real one; captured frames are compared against a byte-level reference model.
`timescale 1ns / 1ps

module tb_telem_frame_tx;

    localparam int unsigned NB = 6;
    localparam logic [7:0]  H  = 8'hA5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            snd;
    logic [8*NB-1:0] payload;
    logic            tx_done;
    logic            trmt;
    logic [7:0]      tx_data;
    logic            busy;
    logic            frm_done;

    int tests = 0;
    int fails = 0;

    bit         auto_tx = 1'b0;
    bit [7:0]   got[$];
    int         n_trmt = 0;
    int         n_frm = 0;
    longint     cyc = 0;
    longint     last_trmt = -100;

    always #5 clk = ~clk;

    telem_frame_tx #(
        .NUM_BYTES(NB),
        .HDR      (H)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .snd     (snd),
        .payload (payload),
        .tx_done (tx_done),
        .trmt    (trmt),
        .tx_data (tx_data),
        .busy    (busy),
        .frm_done(frm_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: byte k of the frame (0 = header, NB+1 = checksum).
    function automatic logic [7:0] exp_byte(input logic [8*NB-1:0] pl, input int k);
        int         s;
        logic [7:0] s8;
        if (k == 0) return H;
        if (k <= int'(NB)) return pl[8*(int'(NB)-k) +: 8];
        s = int'(H);
        for (int j = 0; j < int'(NB); j++) s += int'(pl[8*j +: 8]);
        s8 = s[7:0];
        return ~s8;
    endfunction

    // Monitor: record every byte handed to the transmitter and every frm_done.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (trmt === 1'b1) begin
                got.push_back(tx_data);
                n_trmt++;
                check("trmt_spacing", 32'(cyc - last_trmt >= 3), 1);
                last_trmt = cyc;
            end
            if (frm_done === 1'b1) n_frm++;
        end
    end

    // Behavioural transmitter: clears tx_done on trmt, raises it a few cycles later.
    initial begin
        int cnt;
        bit pend;
        pend = 1'b0;
        cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_tx) begin
                if (trmt === 1'b1) begin
                    tx_done = 1'b0;
                    pend    = 1'b1;
                    cnt     = $urandom_range(3, 12);
                end else if (pend) begin
                    if (cnt == 0) begin
                        tx_done = 1'b1;
                        pend    = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_snd(input logic [8*NB-1:0] pl);
        payload = pl;
        snd     = 1'b1;
        @(posedge clk);
        #2;
        snd = 1'b0;
    endtask

    task automatic wait_frm(input string tag);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            if (frm_done === 1'b1) break;
        end
        check({tag, "_timeout"}, 32'(i < 3000), 1);
    endtask

    task automatic check_frame(input logic [8*NB-1:0] pl, input string tag);
        check({tag, "_len"}, got.size(), NB + 2);
        for (int k = 0; k < int'(NB) + 2; k++) begin
            check($sformatf("%s_byte%0d", tag, k), (k < got.size()) ? {24'h0, got[k]} : 32'hx,
                  {24'h0, exp_byte(pl, k)});
        end
    endtask

    function automatic logic [8*NB-1:0] rnd_pl();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [8*NB-1:0] pl, pl2;

        rst_n   = 1'b0;
        snd     = 1'b0;
        payload = '0;
        tx_done = 1'b0;

        // Reset state and quiet idle.
        repeat (3) @(posedge clk);
        #2;
        check("rst_trmt", trmt, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_frm_done", frm_done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            check("idle_trmt", trmt, 0);
            check("idle_tx_data", tx_data, 8'h00);
            check("idle_busy", busy, 0);
            check("idle_frm_done", frm_done, 0);
        end
        check("idle_no_trmt", n_trmt, 0);

        // Basic frame.
        auto_tx = 1'b1;
        got.delete();
        n_trmt = 0;
        n_frm  = 0;
        pl = 48'h010203040506;
        pulse_snd(pl);
        check("f1_hdr_trmt", trmt, 1);
        check("f1_hdr_data", tx_data, 8'hA5);
        check("f1_busy", busy, 1);
        wait_frm("f1");
        check("f1_busy_end", busy, 0);
        check("f1_chk45", (got.size() == 8) ? {24'h0, got[7]} : 32'hx, 8'h45);
        @(posedge clk);
        #2;
        check("f1_frm_done_1cyc", frm_done, 0);
        check_frame(pl, "f1");
        check("f1_ntrmt", n_trmt, 8);
        check("f1_nfrm", n_frm, 1);

        // Checksum wraparound.
        got.delete();
        n_trmt = 0;
        pl = 48'hFFFFFFFFFFFF;
        pulse_snd(pl);
        wait_frm("f2");
        check("f2_chk60", (got.size() == 8) ? {24'h0, got[7]} : 32'hx, 8'h60);
        check_frame(pl, "f2");

        // Random payloads with snd and payload disturbances mid-frame.
        for (int f = 0; f < 4; f++) begin
            got.delete();
            n_trmt = 0;
            n_frm  = 0;
            pl = rnd_pl();
            pulse_snd(pl);
            for (int d = 0; d < 3; d++) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #2;
                pulse_snd(rnd_pl());
            end
            wait_frm("fr");
            check_frame(pl, $sformatf("fr%0d", f));
            repeat (30) @(posedge clk);
            #2;
            check("fr_ntrmt", n_trmt, 8);
            check("fr_nfrm", n_frm, 1);
            check("fr_idle_busy", busy, 0);
        end

        // Back-to-back: snd in the frm_done cycle.
        got.delete();
        n_trmt = 0;
        pl  = rnd_pl();
        pl2 = rnd_pl();
        pulse_snd(pl);
        wait_frm("bb1");
        check_frame(pl, "bb1");
        got.delete();
        pulse_snd(pl2);
        check("bb_hdr_trmt", trmt, 1);
        check("bb_hdr_data", tx_data, 8'hA5);
        wait_frm("bb2");
        check_frame(pl2, "bb2");

        // Manual tx_done: stuck high, then a rise, then reset mid-frame.
        auto_tx = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        tx_done = 1'b1;
        got.delete();
        n_trmt = 0;
        n_frm  = 0;
        pl = rnd_pl();
        pulse_snd(pl);
        check("m_hdr_trmt", trmt, 1);
        repeat (50) @(posedge clk);
        #2;
        check("m_stuck_ntrmt", n_trmt, 1);
        check("m_stuck_busy", busy, 1);
        tx_done = 1'b0;
        @(posedge clk);
        #2;
        tx_done = 1'b1;
        @(posedge clk);
        #2;
        check("m_lat1_trmt", trmt, 0);
        @(posedge clk);
        #2;
        check("m_lat2_trmt", trmt, 1);
        check("m_lat2_data", tx_data, exp_byte(pl, 1));
        tx_done = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_trmt", trmt, 0);
        check("mr_tx_data", tx_data, 8'h00);
        check("mr_busy", busy, 0);
        check("mr_frm_done", frm_done, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n   = 1'b1;
        tx_done = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        check("mr_nfrm", n_frm, 0);
        check("mr_ntrmt", n_trmt, 2);
        check("mr_busy_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
